// File: rtl/apb_resp_pkg28.sv
// Shared types and constants for the APB responder and its register bank.
package apb_resp_pkg28;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int WAIT_W = 3;
    typedef logic [WAIT_W-1:0] wait_t;

    localparam logic [3:0]  REG_ID           = 4'd0;
    localparam logic [3:0]  REG_CTRL         = 4'd1;
    localparam logic [31:0] ID_VALUE_DEFAULT = 32'hA9B0_0028;

endpackage

// File: rtl/apb_regbank28.sv
// Sixteen-word register bank: constant ID word, a 3-bit CTRL wait field and scratch words.
module apb_regbank28
    import apb_resp_pkg28::*;
#(
    parameter logic [31:0] ID_VALUE = ID_VALUE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [3:0]  raddr,
    output logic [31:0] rdata,
    output wait_t       wait_cfg
);

    wait_t       ctrl_q;
    logic [31:0] scratch [2:15];

    // ID is never stored, so a stray write there has nothing to land on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
            for (int i = 2; i < 16; i++) begin
                scratch[i] <= '0;
            end
        end else if (we) begin
            if (waddr == REG_CTRL) begin
                ctrl_q <= wdata[WAIT_W-1:0];
            end else if (waddr != REG_ID) begin
                scratch[waddr] <= wdata;
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (raddr)
            REG_ID:   rdata = ID_VALUE;
            REG_CTRL: rdata = {{(32-WAIT_W){1'b0}}, ctrl_q};
            default:  rdata = scratch[raddr];
        endcase
    end

    assign wait_cfg = ctrl_q;

endmodule

// File: rtl/apb_resp_regs28.sv
// APB responder: setup/access/done sequencing, programmable wait states and error decoding
// in front of apb_regbank28. All response outputs are registered.
module apb_resp_regs28
    import apb_resp_pkg28::*;
#(
    parameter int          PADDR_WIDTH28  = 32,
    parameter int          PWDATA_WIDTH28 = 32,
    parameter int          PRDATA_WIDTH28 = 32,
    parameter int          SLV_INDEX28    = 0,
    parameter logic [31:0] ID_VALUE28     = ID_VALUE_DEFAULT
) (
    input  logic                      pclock28,
    input  logic                      preset28,
    input  logic [PADDR_WIDTH28-1:0]  paddr28,
    input  logic                      prwd28,
    input  logic [PWDATA_WIDTH28-1:0] pwdata28,
    input  logic                      penable28,
    input  logic [15:0]               psel28,
    output logic [PRDATA_WIDTH28-1:0] prdata28,
    output logic                      pready28,
    output logic                      pslverr28
);

    state_t                    state;
    wait_t                     cnt;
    wait_t                     wait_cfg;
    logic [PADDR_WIDTH28-1:0]  addr_q;
    logic                      wr_q;
    logic [PWDATA_WIDTH28-1:0] wdata_q;
    logic [PADDR_WIDTH28-1:0]  cur_addr;
    logic                      sel;
    logic                      setup;
    logic                      cur_wr;
    logic                      cur_err;
    logic                      bank_we;
    logic [31:0]               bank_wdata;
    logic [31:0]               bank_rdata;
    logic [PRDATA_WIDTH28-1:0] rd_resp;
    logic                      unused_psel;

    assign sel         = psel28[SLV_INDEX28];
    assign unused_psel = ^psel28;
    assign setup       = (state != ST_ACCESS) && sel && !penable28;

    // During a setup cycle the response is decided from the live bus, otherwise from the latched transfer.
    assign cur_addr   = setup ? paddr28 : addr_q;
    assign cur_wr     = setup ? prwd28 : wr_q;
    assign cur_err    = (cur_addr[1:0] != 2'b00)
                     || ((cur_addr >> 6) != '0)
                     || (cur_wr && (cur_addr[5:2] == REG_ID));
    assign rd_resp    = (cur_wr || cur_err) ? '0 : PRDATA_WIDTH28'(bank_rdata);
    assign bank_wdata = 32'(wdata_q);
    assign bank_we    = (state == ST_ACCESS) && pready28 && sel && penable28
                     && wr_q && !pslverr28;

    // pready is raised one edge early so it is seen in access cycle W+1; the write
    // commits on the edge that closes that cycle.
    always_ff @(posedge pclock28 or negedge preset28) begin
        if (!preset28) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            pready28  <= 1'b0;
            pslverr28 <= 1'b0;
            prdata28  <= '0;
        end else begin
            pready28  <= 1'b0;
            pslverr28 <= 1'b0;
            prdata28  <= '0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (setup) begin
                        state   <= ST_ACCESS;
                        addr_q  <= paddr28;
                        wr_q    <= prwd28;
                        wdata_q <= pwdata28;
                        cnt     <= wait_cfg;
                        if (wait_cfg == '0) begin
                            pready28  <= 1'b1;
                            pslverr28 <= cur_err;
                            prdata28  <= rd_resp;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (!(sel && penable28)) begin
                        state <= ST_IDLE;
                    end else if (pready28) begin
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt - wait_t'(1);
                        if (cnt == wait_t'(1)) begin
                            pready28  <= 1'b1;
                            pslverr28 <= cur_err;
                            prdata28  <= rd_resp;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    apb_regbank28 #(
        .ID_VALUE (ID_VALUE28)
    ) u_regbank (
        .clk      (pclock28),
        .rst_n    (preset28),
        .we       (bank_we),
        .waddr    (cur_addr[5:2]),
        .wdata    (bank_wdata),
        .raddr    (cur_addr[5:2]),
        .rdata    (bank_rdata),
        .wait_cfg (wait_cfg)
    );

endmodule

// File: tb/tb_apb_resp_regs28.sv
// Randomised and directed bench for apb_resp_regs28 against a word-level register model.
module tb_apb_resp_regs28;

    localparam int          SLV    = 0;
    localparam int          OTHER  = 3;
    localparam logic [31:0] ID_VAL = 32'hA9B0_0028;

    logic        pclock28;
    logic        preset28;
    logic [31:0] paddr28;
    logic        prwd28;
    logic [31:0] pwdata28;
    logic        penable28;
    logic [15:0] psel28;
    logic [31:0] prdata28;
    logic        pready28;
    logic        pslverr28;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_regs [16];
    int          model_ctrl;

    apb_resp_regs28 #(
        .PADDR_WIDTH28  (32),
        .PWDATA_WIDTH28 (32),
        .PRDATA_WIDTH28 (32),
        .SLV_INDEX28    (SLV),
        .ID_VALUE28     (ID_VAL)
    ) dut (
        .pclock28  (pclock28),
        .preset28  (preset28),
        .paddr28   (paddr28),
        .prwd28    (prwd28),
        .pwdata28  (pwdata28),
        .penable28 (penable28),
        .psel28    (psel28),
        .prdata28  (prdata28),
        .pready28  (pready28),
        .pslverr28 (pslverr28)
    );

    initial pclock28 = 1'b0;
    always #5 pclock28 = ~pclock28;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        model_ctrl = 0;
        for (int i = 0; i < 16; i++) model_regs[i] = 32'h0;
    endtask

    function automatic logic [31:0] modelRead(input int idx);
        if (idx == 0) return ID_VAL;
        if (idx == 1) return 32'(model_ctrl);
        return model_regs[idx];
    endfunction

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_pready"}, {31'b0, pready28}, 32'h0);
        checkOutput({tag, "_pslverr"}, {31'b0, pslverr28}, 32'h0);
        checkOutput({tag, "_prdata"}, prdata28, 32'h0);
    endtask

    task automatic idleCycle();
        @(posedge pclock28); #1;
        psel28    = 16'h0;
        penable28 = 1'b0;
    endtask

    // One full transfer; keep=1 leaves the bus driven so the next call's setup lands in the done cycle.
    task automatic applyStimulus(input logic [31:0] addr, input logic wr,
                                 input logic [31:0] data, input bit keep);
        int          k;
        bit          got;
        bit          exp_err;
        int          exp_lat;
        logic [31:0] exp_rd;
        int          idx;
        idx     = int'(addr[5:2]);
        exp_err = (addr[1:0] != 2'b00) || (addr[31:6] != 26'h0) || (wr && idx == 0);
        exp_lat = model_ctrl + 1;
        exp_rd  = (wr || exp_err) ? 32'h0 : modelRead(idx);
        @(posedge pclock28); #1;
        psel28    = 16'h1 << SLV;
        penable28 = 1'b0;
        paddr28   = addr;
        prwd28    = wr;
        pwdata28  = data;
        checkOutput("setup_pready", {31'b0, pready28}, 32'h0);
        checkOutput("setup_prdata", prdata28, 32'h0);
        @(posedge pclock28); #1;
        penable28 = 1'b1;
        k   = 1;
        got = 0;
        while (!got && k <= 20) begin
            if (pready28) got = 1;
            else begin
                k++;
                @(posedge pclock28); #1;
            end
        end
        checkOutput("pready_seen", {31'b0, got}, 32'h1);
        checkOutput("latency", 32'(k), 32'(exp_lat));
        checkOutput("pslverr", {31'b0, pslverr28}, {31'b0, exp_err});
        checkOutput("prdata", prdata28, exp_rd);
        if (wr && !exp_err) begin
            if (idx == 1) model_ctrl = int'(data[2:0]);
            else if (idx >= 2) model_regs[idx] = data;
        end
        if (!keep) begin
            idleCycle();
            checkOutput("pready_pulse", {31'b0, pready28}, 32'h0);
        end
    endtask

    task automatic abortStimulus(input logic [31:0] addr, input bit drop_sel);
        @(posedge pclock28); #1;
        psel28    = 16'h1 << SLV;
        penable28 = 1'b0;
        paddr28   = addr;
        prwd28    = 1'b1;
        pwdata28  = 32'hCAFE_F00D;
        @(posedge pclock28); #1;
        penable28 = 1'b1;
        checkOutput("abort_c1", {31'b0, pready28}, 32'h0);
        @(posedge pclock28); #1;
        if (drop_sel) psel28 = 16'h0;
        else penable28 = 1'b0;
        checkOutput("abort_c2", {31'b0, pready28}, 32'h0);
        @(posedge pclock28); #1;
        psel28    = 16'h0;
        penable28 = 1'b0;
        checkOutput("abort_c3", {31'b0, pready28}, 32'h0);
        idleCycle();
        checkOutput("abort_c4", {31'b0, pready28}, 32'h0);
    endtask

    initial begin
        logic [31:0] addr;
        logic [31:0] data;
        int          r;
        preset28  = 1'b0;
        paddr28   = 32'h0;
        prwd28    = 1'b0;
        pwdata28  = 32'h0;
        penable28 = 1'b0;
        psel28    = 16'h0;
        modelReset();
        repeat (2) @(posedge pclock28);
        #1;
        checkQuiet("reset");
        preset28 = 1'b1;

        $display("[TB] ID read and wait-state programming");
        applyStimulus(32'h00, 1'b0, 32'h0, 0);
        applyStimulus(32'h04, 1'b1, 32'h0000_000B, 0);
        applyStimulus(32'h04, 1'b0, 32'h0, 0);
        applyStimulus(32'h08, 1'b1, 32'hDEAD_BEEF, 0);
        applyStimulus(32'h08, 1'b0, 32'h0, 0);

        $display("[TB] error responses");
        applyStimulus(32'h00, 1'b1, 32'h0000_1234, 0);
        applyStimulus(32'h40, 1'b1, 32'h5555_AAAA, 0);
        applyStimulus(32'h0A, 1'b0, 32'h0, 0);
        applyStimulus(32'h00, 1'b0, 32'h0, 0);
        applyStimulus(32'h04, 1'b0, 32'h0, 0);
        applyStimulus(32'h08, 1'b0, 32'h0, 0);

        $display("[TB] back-to-back writes");
        applyStimulus(32'h0C, 1'b1, 32'h1111_2222, 1);
        applyStimulus(32'h10, 1'b1, 32'h3333_4444, 1);
        applyStimulus(32'h0C, 1'b0, 32'h0, 1);
        applyStimulus(32'h10, 1'b0, 32'h0, 0);

        $display("[TB] aborts and mid-transfer reset");
        applyStimulus(32'h04, 1'b1, 32'h0000_0002, 0);
        abortStimulus(32'h14, 1'b1);
        abortStimulus(32'h14, 1'b0);
        applyStimulus(32'h14, 1'b0, 32'h0, 0);
        @(posedge pclock28); #1;
        psel28    = 16'h1 << SLV;
        penable28 = 1'b0;
        paddr28   = 32'h14;
        prwd28    = 1'b1;
        pwdata28  = 32'h0BAD_0BAD;
        @(posedge pclock28); #1;
        penable28 = 1'b1;
        checkOutput("rst_pre_pready", {31'b0, pready28}, 32'h0);
        #2 preset28 = 1'b0;
        #1 checkQuiet("rst_async");
        @(posedge pclock28); #1;
        psel28    = 16'h0;
        penable28 = 1'b0;
        checkQuiet("rst_hold");
        @(posedge pclock28); #1;
        preset28 = 1'b1;
        modelReset();
        applyStimulus(32'h14, 1'b0, 32'h0, 0);
        applyStimulus(32'h08, 1'b0, 32'h0, 0);
        applyStimulus(32'h04, 1'b0, 32'h0, 0);

        $display("[TB] foreign select and stray penable");
        applyStimulus(32'h18, 1'b1, 32'h7777_8888, 0);
        @(posedge pclock28); #1;
        psel28    = 16'h1 << OTHER;
        penable28 = 1'b0;
        paddr28   = 32'h18;
        prwd28    = 1'b1;
        pwdata28  = 32'hFFFF_0000;
        for (int i = 0; i < 5; i++) begin
            @(posedge pclock28); #1;
            penable28 = 1'b1;
            checkOutput("foreign_pready", {31'b0, pready28}, 32'h0);
        end
        idleCycle();
        psel28    = 16'h1 << SLV;
        penable28 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge pclock28); #1;
            checkOutput("stray_pready", {31'b0, pready28}, 32'h0);
        end
        psel28    = 16'h0;
        penable28 = 1'b0;
        applyStimulus(32'h18, 1'b0, 32'h0, 0);

        $display("[TB] random transfers");
        for (int n = 0; n < 80; n++) begin
            r    = int'($urandom_range(0, 9));
            addr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            if (r == 7) addr[1:0] = 2'($urandom_range(1, 3));
            if (r == 8) addr[6 + $urandom_range(0, 25)] = 1'b1;
            data = $urandom;
            if (addr[5:2] == 4'd1) data[31:3] = 29'($urandom_range(0, 3));
            applyStimulus(addr, 1'($urandom_range(0, 1)), data, 1'($urandom_range(0, 1)));
        end
        idleCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
